// File: rtl/arb_rr8_dec_if.sv
// ============================================================================
// Module   : arb_rr8_dec_if
// Brief    : Request/grant bundle between eight masters and arb_rr8_dec.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface arb_rr8_dec_if;
  logic       en;
  logic [7:0] req;
  logic [7:0] grant_n;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  modport master (
    output en, req,
    input  grant_n, gnt_idx, gnt_valid, timeout
  );

  modport slave (
    input  en, req,
    output grant_n, gnt_idx, gnt_valid, timeout
  );
endinterface

`default_nettype wire

// File: rtl/arb_rr8_dec.sv
// ============================================================================
// Module   : arb_rr8_dec
// Brief    : 8-way round-robin arbiter, active-low one-hot grant plus index.
//            Optional hold timeout compiled in with `define ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module arb_rr8_dec #(
  parameter int MAX_HOLD = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  arb_rr8_dec_if.slave  bus
);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  if ((MAX_HOLD < 2) || (MAX_HOLD > 255)) begin : g_bad_max_hold
    $error("arb_rr8_dec: MAX_HOLD must be within 2..255");
  end

  state_t     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [7:0] grant_n_q, grant_n_d;
  logic [2:0] idx_q, idx_d;
  logic       valid_q, valid_d;
  logic       timeout_q, timeout_d;
  logic [2:0] w_sel;
  logic       w_force;

  // Rotating priority: lowest offset from ptr_q wins, so scan offsets downward.
  always_comb begin
    w_sel = ptr_q;
    for (int k = 7; k >= 0; k--) begin
      if (bus.req[ptr_q + k[2:0]]) begin
        w_sel = ptr_q + k[2:0];
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  logic [7:0] hold_q, hold_d;

  assign w_force = (hold_q == 8'(MAX_HOLD)) && bus.req[idx_q];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_q <= 8'd0;
    end else begin
      hold_q <= hold_d;
    end
  end

  always_comb begin
    hold_d = hold_q;
    if (state_q == S_IDLE) begin
      hold_d = 8'd1;
    end else if (bus.req[idx_q] && !w_force) begin
      hold_d = hold_q + 8'd1;
    end
  end
`else
  assign w_force = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      ptr_q     <= 3'd0;
      grant_n_q <= 8'hFF;
      idx_q     <= 3'd0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      grant_n_q <= grant_n_d;
      idx_q     <= idx_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    grant_n_d = grant_n_q;
    idx_d     = idx_q;
    valid_d   = valid_q;
    timeout_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.en && (|bus.req)) begin
          state_d   = S_GRANT;
          grant_n_d = ~(8'b0000_0001 << w_sel);
          idx_d     = w_sel;
          valid_d   = 1'b1;
          ptr_d     = w_sel + 3'd1;
        end
      end
      S_GRANT: begin
        // A voluntary drop takes precedence, so timeout only flags a true overrun.
        if (!bus.req[idx_q] || w_force) begin
          state_d   = S_IDLE;
          grant_n_d = 8'hFF;
          valid_d   = 1'b0;
          timeout_d = bus.req[idx_q];
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.grant_n   = grant_n_q;
  assign bus.gnt_idx   = idx_q;
  assign bus.gnt_valid = valid_q;
  assign bus.timeout   = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_arb_rr8_dec.sv
// ============================================================================
// Module   : tb_arb_rr8_dec
// Brief    : Directed self-checking bench for arb_rr8_dec.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_arb_rr8_dec;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_miss;

  arb_rr8_dec_if bus ();

  arb_rr8_dec #(.MAX_HOLD(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_grant(input string tag, input int idx);
    logic [7:0] exp_n;
    exp_n = 8'hFF;
    exp_n[idx] = 1'b0;
    check_val({tag, "_grant_n"}, 32'(bus.grant_n), 32'(exp_n));
    check_val({tag, "_idx"}, 32'(bus.gnt_idx), 32'(idx));
    check_val({tag, "_valid"}, 32'(bus.gnt_valid), 32'd1);
  endtask

  task automatic check_idle(input string tag);
    check_val({tag, "_grant_n"}, 32'(bus.grant_n), 32'hFF);
    check_val({tag, "_valid"}, 32'(bus.gnt_valid), 32'd0);
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    rst_n   = 1'b0;
    bus.en  = 1'b1;
    bus.req = 8'h00;

    // Reset for two cycles
    step();
    step();
    check_idle("rst");
    check_val("rst_idx", 32'(bus.gnt_idx), 32'd0);
    check_val("rst_tmo", 32'(bus.timeout), 32'd0);

    // Single request
    rst_n   = 1'b1;
    bus.req = 8'h04;
    step();
    check_grant("single", 2);
    bus.req = 8'h00;
    step();
    check_idle("single_rel");
    check_val("single_rel_idx", 32'(bus.gnt_idx), 32'd2);

    // Round robin from ptr=0 after a fresh reset
    rst_n = 1'b0;
    step();
    rst_n   = 1'b1;
    bus.req = 8'hFF;
    for (int i = 0; i < 9; i++) begin
      step();
      check_grant($sformatf("rr%0d", i), i % 8);
      bus.req = 8'hFF & ~(8'h01 << (i % 8));
      step();
      check_idle($sformatf("rr%0d_gap", i));
      bus.req = (i == 8) ? 8'h00 : 8'hFF;
    end

    // Pointer wrap: grant 6, then 0x81 gives 7 before 0
    bus.req = 8'h40;
    step();
    check_grant("wrap6", 6);
    bus.req = 8'h00;
    step();
    bus.req = 8'h81;
    step();
    check_grant("wrap7", 7);
    bus.req = 8'h01;
    step();
    check_idle("wrap_gap");
    step();
    check_grant("wrap0", 0);
    bus.req = 8'h00;
    step();

    // Enable gating: running grant completes, no new grant while en=0
    bus.req = 8'h08;
    step();
    check_grant("en_g3", 3);
    bus.en  = 1'b0;
    bus.req = 8'h28;
    step();
    check_grant("en_hold3a", 3);
    step();
    check_grant("en_hold3b", 3);
    bus.req = 8'h20;
    step();
    check_idle("en_rel3");
    step();
    check_idle("en_block5a");
    step();
    check_idle("en_block5b");
    bus.en = 1'b1;
    step();
    check_grant("en_g5", 5);
    bus.req = 8'h00;
    step();

    // Hold limit
    bus.req = 8'h02;
    step();
`ifdef ARB_TIMEOUT_EN
    for (int c = 1; c <= 16; c++) begin
      check_grant($sformatf("tmo_c%0d", c), 1);
      check_val($sformatf("tmo_c%0d_pulse", c), 32'(bus.timeout), 32'd0);
      if (c < 16) step();
    end
    step();
    check_idle("tmo_rel");
    check_val("tmo_pulse", 32'(bus.timeout), 32'd1);
    step();
    check_grant("tmo_regrant", 1);
    check_val("tmo_pulse_end", 32'(bus.timeout), 32'd0);
    for (int c = 2; c <= 16; c++) begin
      step();
      check_grant($sformatf("tmo2_c%0d", c), 1);
    end
    bus.req = 8'h00;
    step();
    check_idle("tmo2_rel");
    check_val("tmo2_no_pulse", 32'(bus.timeout), 32'd0);
`else
    for (int c = 1; c <= 20; c++) begin
      check_grant($sformatf("hold_c%0d", c), 1);
      check_val($sformatf("hold_c%0d_tmo", c), 32'(bus.timeout), 32'd0);
      step();
    end
    bus.req = 8'h00;
    step();
    check_idle("hold_rel");
    check_val("hold_rel_tmo", 32'(bus.timeout), 32'd0);
`endif
    step();

    // Reset mid-grant on idx 5; ptr must restart at 0
    bus.req = 8'h20;
    step();
    check_grant("mid_g5", 5);
    rst_n   = 1'b0;
    bus.req = 8'h82;
    step();
    check_idle("mid_rst");
    check_val("mid_rst_idx", 32'(bus.gnt_idx), 32'd0);
    check_val("mid_rst_tmo", 32'(bus.timeout), 32'd0);
    rst_n = 1'b1;
    step();
    check_grant("mid_first", 1);
    bus.req = 8'h00;
    step();
    check_idle("mid_end");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire
